// File: rtl/control_sequencer.sv
// Control sequencer: owns the IDLE/LOAD/FETCH/DECODE/EXEC/MEMWAIT/HALT stage machine and
// drives every datapath enable. Define CU_PERF_CNT_EN to build the retired-instruction counter.
module control_sequencer #(
  parameter int IR_W       = 12,
  parameter int ADDR_W     = 8,
  parameter int PMEM_DEPTH = 256,
  parameter int ALU_MODE_W = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  load_valid,
  input  logic                  load_last,
  input  logic                  dmem_ready,
  input  logic [IR_W-1:0]       ir,
  input  logic [3:0]            sr,
  output logic [2:0]            stage_o,
  output logic [ADDR_W-1:0]     load_addr,
  output logic                  pc_e,
  output logic                  acc_e,
  output logic                  sr_e,
  output logic                  ir_e,
  output logic                  dr_e,
  output logic                  pmem_e,
  output logic                  pmem_le,
  output logic                  dmem_e,
  output logic                  dmem_we,
  output logic                  alu_e,
  output logic                  mux1_sel,
  output logic                  mux2_sel,
  output logic                  pr_e,
  output logic [ALU_MODE_W-1:0] alu_mode,
  output logic                  halted,
  output logic [31:0]           instr_cnt
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'b000,
    S_LOAD    = 3'b001,
    S_FETCH   = 3'b010,
    S_DECODE  = 3'b011,
    S_EXEC    = 3'b100,
    S_MEMWAIT = 3'b101,
    S_HALT    = 3'b110
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PMEM_DEPTH - 1);

  state_t              state, state_n;
  logic [ADDR_W-1:0]   load_addr_n;
  logic [3:0]          op, sub;
  logic                is_mem_op;

  assign op        = ir[IR_W-1 -: 4];
  assign sub       = ir[IR_W-5 -: 4];
  assign is_mem_op = (op[3:1] == 3'b001);

  // Immediate bits below the sub field feed the datapath directly, not this block.
  logic unused_imm;
  assign unused_imm = ^ir[IR_W-9:0];

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      load_addr <= '0;
    end else begin
      state     <= state_n;
      load_addr <= load_addr_n;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_n     = state;
    load_addr_n = load_addr;
    pc_e        = 1'b0;
    acc_e       = 1'b0;
    sr_e        = 1'b0;
    ir_e        = 1'b0;
    dr_e        = 1'b0;
    pmem_e      = 1'b0;
    pmem_le     = 1'b0;
    dmem_e      = 1'b0;
    dmem_we     = 1'b0;
    alu_e       = 1'b0;
    mux1_sel    = 1'b0;
    mux2_sel    = 1'b0;
    pr_e        = 1'b0;
    alu_mode    = '0;

    unique case (state)
      S_IDLE, S_HALT: begin
        if (start) begin
          state_n     = S_LOAD;
          load_addr_n = '0;
        end
      end

      S_LOAD: begin
        pmem_e  = load_valid;
        pmem_le = load_valid;
        if (load_valid) begin
          // Depth limit ends the load before load_addr could wrap.
          if (load_last || load_addr == LAST_ADDR) begin
            state_n     = S_FETCH;
            load_addr_n = '0;
          end else begin
            load_addr_n = load_addr + ADDR_W'(1);
          end
        end
      end

      S_FETCH: begin
        ir_e    = 1'b1;
        pmem_e  = 1'b1;
        state_n = S_DECODE;
      end

      S_DECODE: begin
        if (is_mem_op) begin
          dr_e    = 1'b1;
          dmem_e  = 1'b1;
          state_n = dmem_ready ? S_EXEC : S_MEMWAIT;
        end else begin
          state_n = S_EXEC;
        end
      end

      S_MEMWAIT: begin
        dr_e   = 1'b1;
        dmem_e = 1'b1;
        if (dmem_ready) state_n = S_EXEC;
      end

      S_EXEC: begin
        state_n = S_FETCH;
        if (op[3]) begin
          pc_e     = 1'b1;
          acc_e    = 1'b1;
          sr_e     = 1'b1;
          alu_e    = 1'b1;
          alu_mode = ALU_MODE_W'(op[2:0]);
          mux2_sel = 1'b1;
        end else if (op[3:2] == 2'b01) begin
          pc_e     = 1'b1;
          mux1_sel = sr[op[1:0]];
        end else if (is_mem_op) begin
          alu_e    = 1'b1;
          alu_mode = ALU_MODE_W'(sub);
          if (op[0]) begin
            acc_e = 1'b1;
            sr_e  = 1'b1;
            pc_e  = 1'b1;
          end else begin
            // Store holds the write until memory accepts; PC moves only on that cycle.
            dmem_e  = 1'b1;
            dmem_we = 1'b1;
            if (dmem_ready) begin
              sr_e = 1'b1;
              pc_e = 1'b1;
            end else begin
              state_n = S_EXEC;
            end
          end
        end else if (op[0]) begin
          pc_e     = 1'b1;
          mux1_sel = 1'b1;
        end else begin
          unique case (sub)
            4'b1111: begin
              pc_e = 1'b1;
              pr_e = 1'b1;
            end
            4'b1110: state_n = S_HALT;
            default: pc_e = 1'b1;
          endcase
        end
      end

      default: state_n = S_IDLE;
    endcase
  end

  assign stage_o = state;
  assign halted  = (state == S_HALT);

`ifdef CU_PERF_CNT_EN
  logic        retire;
  logic        start_accept;
  logic [31:0] cnt_q;

  assign retire       = (state == S_EXEC) && (state_n != S_EXEC);
  assign start_accept = start && ((state == S_IDLE) || (state == S_HALT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            cnt_q <= '0;
    else if (start_accept) cnt_q <= '0;
    else if (retire)       cnt_q <= cnt_q + 32'd1;
  end

  assign instr_cnt = cnt_q;
`else
  assign instr_cnt = '0;
`endif

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Next-generation control unit that owns its own stage state machine. The previous unit took the stage from an external counter.
- Adds a program-load address counter, data-memory wait-state handshake and a HALT instruction.
- Instruction width and ALU-mode width are parametrised.
- Sits between the program/data memories and the datapath; drives every datapath enable.

Parameters:
- IR_W, 12, instruction width (>=12). op=ir[IR_W-1:IR_W-4], sub=ir[IR_W-5:IR_W-8], imm=ir[IR_W-5:0].
- ADDR_W, 8, program-memory address width.
- PMEM_DEPTH, 256, words loaded before automatic exit from LOAD (<=2^ADDR_W).
- ALU_MODE_W, 4, ALU mode width (>=4).

Ports:
- clk  in  1  clock. Single clock; all state changes on rising edge.
- rst_n  in  1  asynchronous active-low reset. Reset is asynchronous, active-low.
- start  in  1  pulse: leave IDLE/HALT into LOAD.
- load_valid  in  1  program word present on load bus this cycle.
- load_last  in  1  qualifies load_valid: final word, end LOAD early.
- dmem_ready  in  1  data memory accepts/returns this cycle.
- ir  in  IR_W  instruction register contents.
- sr  in  4  status flags {Z,C,S,O}; sr[3]=Z.
- stage_o  out  3  current state encoding.
- load_addr  out  ADDR_W  program-memory write address during LOAD.
- pc_e, acc_e, sr_e, ir_e, dr_e, pmem_e, pmem_le, dmem_e, dmem_we, alu_e, mux1_sel, mux2_sel, pr_e  out  1 each  datapath enables/selects. Same meanings as the existing datapath.
- alu_mode  out  ALU_MODE_W  ALU operation; zero-extended from source field.
- halted  out  1  high while in HALT.
- instr_cnt  out  32  retired-instruction count (see Optional Feature).

Behaviour:
- States: IDLE=000, LOAD=001, FETCH=010, DECODE=011, EXEC=100, MEMWAIT=101, HALT=110. 111 is illegal and goes to IDLE next cycle.
- Enable outputs are combinational from state, ir, sr and dmem_ready. Every enable defaults to 0 in every state.
- Reset (async, any state, mid-operation included): state=IDLE, load_addr=0, instr_cnt=0, halted=0, all enables 0.
- IDLE: all enables 0. start goes to LOAD with load_addr=0.
- LOAD: pmem_e=pmem_le=load_valid.
  - Each load_valid increments load_addr.
  - load_valid with (load_last or load_addr==PMEM_DEPTH-1) goes to FETCH and clears load_addr to 0.
  - No load_valid: stay in LOAD, no increment.
- FETCH: ir_e=pmem_e=1. Always goes to DECODE; one cycle.
- DECODE:
  - Memory op (op[3:1]==001): dr_e=dmem_e=1. If dmem_ready go to EXEC, else go to MEMWAIT.
  - Otherwise all enables 0 and go to EXEC.
- MEMWAIT: dr_e=dmem_e=1. Stay until dmem_ready, then go to EXEC. No cycle limit.
- EXEC (exactly one decode case):
  - op[3]=1 (immediate ALU): pc_e, acc_e, sr_e, alu_e=1; alu_mode=op[2:0]; mux2_sel=1.
  - op[3:2]=01 (jump): pc_e=1; mux1_sel=sr[op[1:0]].
  - op[3:1]=001 (memory ALU): alu_e=1; alu_mode=sub.
    - If op[0]=1: acc_e=sr_e=pc_e=1.
    - If op[0]=0 (store): dmem_e=dmem_we=1. sr_e and pc_e are asserted only in a cycle with dmem_ready. Without dmem_ready, stay in EXEC with outputs held. PC therefore advances exactly once.
  - op=0001: pc_e=1, mux1_sel=1.
  - op=0000, sub=1111: pc_e=1, pr_e=1.
  - op=0000, sub=1110 (HALT, new): no enables; go to HALT.
  - op=0000, other sub: NOP, pc_e=1.
- EXEC exit: goes to FETCH once its final cycle completes, except HALT.
- HALT: halted=1, all enables 0.
  - start goes to LOAD.
  - load_valid is ignored.
- Retire: an instruction retires on the EXEC cycle that leaves EXEC, HALT included.
- Wrap: load_addr never wraps inside LOAD; PMEM_DEPTH terminates first.
- Simultaneous: load_last without load_valid is ignored.

Optional Feature:
- Macro: CU_PERF_CNT_EN.
- Defined: instr_cnt increments by 1 on every retire. Wraps 0xFFFFFFFF to 0. Cleared by reset and by start.
- Undefined: instr_cnt tied to 0; no counter flops.

Test Plan:
- Reset then start, 3 load_valid pulses, third with load_last → load_addr 0,1,2 with pmem_le high on those cycles; FETCH next cycle; load_addr=0.
- IR_W=12, ir=0x9A5 (ADD imm, op 1001) → DECODE has no enables; EXEC has alu_mode=1, mux2_sel=1, pc_e=acc_e=sr_e=1; next state FETCH; instr_cnt=1.
- ir=0x230 (store, mode 3), dmem_ready low 2 cycles in DECODE and 3 cycles in EXEC → MEMWAIT 2 cycles. EXEC lasts 4 cycles with dmem_we high throughout; pc_e and sr_e pulse once, on the ready cycle.
- Jump ir=0x7xx with sr=1000 → mux1_sel=1. Same with sr=0000 → mux1_sel=0. pc_e=1 in both cases.
- ir=0x0E0 (HALT) → HALT entered; halted=1; enables stay 0 for 20 cycles. start → LOAD.
- rst_n low mid-MEMWAIT → state 000 and all outputs 0 immediately, without waiting for a clock edge. With CU_PERF_CNT_EN defined, instr_cnt=0.
